// File: rtl/ex_mem_skid_stage.sv
// EX->MEM stage register with a two-entry skid buffer, registered ready,
// synchronous flush and a saturating stall counter.
module ex_mem_skid_stage #(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_adder,
  input  logic [XLEN-1:0]   in_alu,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_adder,
  output logic [XLEN-1:0]   out_alu,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   adder;
    logic [XLEN-1:0]   alu;
    logic              zero;
    logic [XLEN-1:0]   wdata;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  ent_t   main_q;
  ent_t   skid_q;
  ent_t   in_e;
  logic   in_fire;
  logic   out_fire;

  assign in_e = '{
    adder: in_adder,
    alu:   in_alu,
    zero:  in_zero,
    wdata: in_wdata,
    rd:    in_rd,
    ctrl:  in_ctrl
  };

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_adder = main_q.adder;
  assign out_alu   = main_q.alu;
  assign out_zero  = main_q.zero;
  assign out_wdata = main_q.wdata;
  assign out_rd    = main_q.rd;
  // A bubble must never write a register, memory or take a branch.
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready &&
          stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        state       <= EMPTY;
        out_valid   <= 1'b0;
        in_ready    <= 1'b1;
        main_q.ctrl <= '0;
        skid_q.ctrl <= '0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q    <= in_e;
              state     <= BUSY;
              out_valid <= 1'b1;
            end
          end
          BUSY: begin
            if (in_fire && out_fire) begin
              main_q <= in_e;
            end else if (in_fire) begin
              skid_q   <= in_e;
              state    <= FULL;
              in_ready <= 1'b0;
            end else if (out_fire) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is low here, so only the drain path applies.
            if (out_fire) begin
              main_q   <= skid_q;
              state    <= BUSY;
              in_ready <= 1'b1;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: a depth-2 FIFO reference model with
// registered ready, compared cycle by cycle under directed and random traffic.
module tb_ex_mem_skid_stage;

  localparam int XLEN   = 64;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 6;
  localparam int CNT_W  = 4;
  localparam int SATMAX = 15;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_adder;
  logic [XLEN-1:0]   in_alu;
  logic              in_zero;
  logic [XLEN-1:0]   in_wdata;
  logic [RD_W-1:0]   in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_adder;
  logic [XLEN-1:0]   out_alu;
  logic              out_zero;
  logic [XLEN-1:0]   out_wdata;
  logic [RD_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  ex_mem_skid_stage #(
    .XLEN(XLEN), .RD_W(RD_W),
    .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_adder(in_adder), .in_alu(in_alu),
    .in_zero(in_zero), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_adder(out_adder), .out_alu(out_alu),
    .out_zero(out_zero), .out_wdata(out_wdata),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [XLEN-1:0]   adder;
    logic [XLEN-1:0]   alu;
    logic              zero;
    logic [XLEN-1:0]   wdata;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  ent_t q[$];
  int   mstall;
  int   pass;
  int   total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [XLEN-1:0] alu);
    in_valid = v;
    in_alu   = alu;
    in_adder = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom};
    in_zero  = 1'($urandom);
    in_rd    = RD_W'($urandom);
    in_ctrl  = CTRL_W'($urandom);
  endtask

  // Reference: FIFO of depth 2, acceptance decided by occupancy before the edge.
  task automatic tick();
    ent_t e;
    bit   inf;
    bit   outf;
    @(posedge clk);
    e.adder = in_adder; e.alu = in_alu; e.zero = in_zero;
    e.wdata = in_wdata; e.rd = in_rd; e.ctrl = in_ctrl;
    inf  = in_valid && (q.size() < 2);
    outf = (q.size() > 0) && out_ready;
    if (q.size() > 0 && !out_ready && mstall < SATMAX) mstall++;
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(e);
    end
    #1;
  endtask

  task automatic clean_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    mstall = 0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h1234 + XLEN'(i));
      in_ctrl = 6'h3F;
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, out_ctrl, stall_cnt} !== {1'b0, 1'b1, 6'h0, 4'h0})
      $display("FAIL reset_ctl: v=%0b rdy=%0b ctrl=%h cnt=%0d want 0 1 0 0",
               out_valid, in_ready, out_ctrl, stall_cnt);
    else pass++;
    total++;
    if ({out_adder, out_alu, out_zero, out_wdata, out_rd} !== '0)
      $display("FAIL reset_data: alu=%h adder=%h wdata=%h rd=%0d want all 0",
               out_alu, out_adder, out_wdata, out_rd);
    else pass++;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    mstall = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, XLEN'(i));
      tick();
      total++;
      if (out_valid !== 1'b1 || out_alu !== XLEN'(i) || in_ready !== 1'b1)
        $display("FAIL stream_%0d: v=%0b alu=%0d rdy=%0b want 1 %0d 1",
                 i, out_valid, out_alu, in_ready, i);
      else pass++;
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd0)
      $display("FAIL stream_drain: v=%0b cnt=%0d want 0 0", out_valid, stall_cnt);
    else pass++;
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] a, b, c;
    int s0;
    a = 64'hAAAA; b = 64'hBBBB; c = 64'hCCCC;
    s0 = mstall;
    out_ready = 1'b0;
    drive(1'b1, a);
    tick();
    drive(1'b1, b);
    tick();
    total++;
    if (out_alu !== a || in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_full: alu=%h rdy=%0b v=%0b want %h 0 1",
               out_alu, in_ready, out_valid, a);
    else pass++;
    drive(1'b1, c);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_alu !== a || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: alu=%h rdy=%0b want %h 0",
                 i, out_alu, in_ready, a);
      else pass++;
    end
    total++;
    if (int'(stall_cnt) !== ((s0 + 4 > SATMAX) ? SATMAX : s0 + 4))
      $display("FAIL bp_stallcnt: got %0d want %0d", stall_cnt,
               (s0 + 4 > SATMAX) ? SATMAX : s0 + 4);
    else pass++;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_alu !== b || in_ready !== 1'b1)
      $display("FAIL bp_drain_b: alu=%h rdy=%0b want %h 1", out_alu, in_ready, b);
    else pass++;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_alu !== c || out_valid !== 1'b1)
      $display("FAIL bp_drain_c: alu=%h v=%0b want %h 1", out_alu, out_valid, c);
    else pass++;
    tick();
    total++;
    if (out_valid !== 1'b0 || q.size() != 0)
      $display("FAIL bp_empty: v=%0b want 0", out_valid);
    else pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 64'hD0); tick();
    drive(1'b1, 64'hE0); tick();
    drive(1'b1, 64'hF0);
    in_ctrl = 6'h3F;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 6'h0 || in_ready !== 1'b1)
      $display("FAIL flush_full: v=%0b ctrl=%h rdy=%0b want 0 00 1",
               out_valid, out_ctrl, in_ready);
    else pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== 6'h0)
        $display("FAIL flush_gone_%0d: v=%0b ctrl=%h alu=%h want 0 00",
                 i, out_valid, out_ctrl, out_alu);
      else pass++;
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, XLEN'($urandom));
      in_ctrl = 6'h3F;
      tick();
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== 6'h0)
        $display("FAIL bubble_%0d: v=%0b ctrl=%h want 0 00", i, out_valid, out_ctrl);
      else pass++;
    end
  endtask

  task automatic test_saturation();
    clean_reset();
    drive(1'b1, 64'h55);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (int'(stall_cnt) !== ((i > SATMAX) ? SATMAX : i) || out_alu !== 64'h55)
        $display("FAIL sat_%0d: cnt=%0d alu=%h want %0d 55",
                 i, stall_cnt, out_alu, (i > SATMAX) ? SATMAX : i);
      else pass++;
    end
    total++;
    if (stall_cnt !== 4'd15)
      $display("FAIL sat_final: cnt=%0d want 15", stall_cnt);
    else pass++;
  endtask

  task automatic test_random();
    clean_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      if (i == 200) clean_reset();
      tick();
      total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          int'(stall_cnt) !== mstall)
        $display("FAIL rnd_ctl_%0d: v=%0b rdy=%0b cnt=%0d want %0b %0b %0d",
                 i, out_valid, in_ready, stall_cnt,
                 q.size() > 0, q.size() < 2, mstall);
      else pass++;
      if (q.size() > 0) begin
        total++;
        if (out_alu !== q[0].alu || out_adder !== q[0].adder ||
            out_zero !== q[0].zero || out_wdata !== q[0].wdata ||
            out_rd !== q[0].rd || out_ctrl !== q[0].ctrl)
          $display("FAIL rnd_data_%0d: alu=%h ctrl=%h rd=%0d want %h %h %0d",
                   i, out_alu, out_ctrl, out_rd, q[0].alu, q[0].ctrl, q[0].rd);
        else pass++;
      end else begin
        total++;
        if (out_ctrl !== 6'h0)
          $display("FAIL rnd_bubble_%0d: ctrl=%h want 00", i, out_ctrl);
        else pass++;
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    pass = 0; total = 0; mstall = 0;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    #12 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
